// File: rtl/pe_mac_pipe_pkg.sv
// Shared types for the PE multiply-accumulate pipeline: opcode enum, element
// widths, stage payload structs and the narrow-and-sign-extend helper.
package pe_pkg;

  typedef enum logic [1:0] {
    PE_MUL   = 2'd0,
    PE_MULH  = 2'd1,
    PE_MACC  = 2'd2,
    PE_NMSAC = 2'd3
  } pe_op_t;

  localparam logic [1:0] SEW_8  = 2'd0;
  localparam logic [1:0] SEW_16 = 2'd1;
  localparam logic [1:0] SEW_32 = 2'd2;

  typedef struct packed {
    pe_op_t      op;
    logic [1:0]  sew;
    logic [31:0] c;
    logic [63:0] prod;
  } s1_pay_t;

  typedef struct packed {
    logic        sat;
    logic [31:0] res;
  } s2_pay_t;

  // Keep the low element-width bits and replicate the element's sign bit.
  function automatic logic [31:0] pe_narrow(input logic [63:0] v, input logic [1:0] sew);
    logic [31:0] r;
    case (sew)
      SEW_8:   r = {{24{v[7]}}, v[7:0]};
      SEW_16:  r = {{16{v[15]}}, v[15:0]};
      default: r = v[31:0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pe_mac_pipe_chk.sv
// Simulation-only protocol checker: flags beats accepted with the reserved
// destination width encoding.
module pe_mac_pipe_chk (
  input logic       clk,
  input logic       n_reset,
  input logic       accept,
  input logic [1:0] res_sew
);

  // Report reserved width encodings at the moment they enter the pipe.
  always_ff @(posedge clk) begin
    if (n_reset && accept && (res_sew == 2'd3)) begin
      $error("pe_mac_pipe: res_sew=3 accepted, treated as 32b");
    end
  end

endmodule

// File: rtl/pe_mac_pipe_pipe_reg.sv
// Generic valid/ready register slice with a synchronous flush that drops
// whatever it holds.
module pe_pipe_reg #(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  logic          valid_q, valid_d;
  logic [PW-1:0] data_q, data_d;
  logic          load_s;

  assign load_s    = !valid_q || out_ready;
  assign in_ready  = !flush && load_s;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Next-state: flush empties the slice, otherwise refill when the consumer frees it.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load_s) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end else begin
        data_d = data_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Slice state registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      valid_q <= 1'b0;
      data_q  <= {PW{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/pe_mac_pipe.sv
// Two-stage MUL/MULH/MACC/NMSAC lane: stage 1 registers the 64b product,
// stage 2 registers the narrowed result. PE_MAC_SAT_EN enables MACC/NMSAC clamping.
module pe_mac_pipe
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [1:0]        res_sew,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] op_c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              out_sat
);

  if (DATA_W != 32) begin : g_bad_width
    $error("pe_mac_pipe: only DATA_W=32 is supported");
  end

  s1_pay_t            s1_in_s, s1_q_s;
  s2_pay_t            s2_in_s, s2_q_s;
  logic               s1_valid_s, s2_ready_s;
  logic signed [63:0] a_ext_s, b_ext_s, c_ext_s, wide_s;
  logic [6:0]         w_s;
`ifdef PE_MAC_SAT_EN
  logic signed [63:0] lim_hi_s, lim_lo_s;
`endif

  // Stage-1 payload: full-precision signed product plus control.
  always_comb begin
    a_ext_s      = {{32{op_a[31]}}, op_a};
    b_ext_s      = {{32{op_b[31]}}, op_b};
    s1_in_s.op   = pe_op_t'(op);
    s1_in_s.sew  = res_sew;
    s1_in_s.c    = op_c;
    s1_in_s.prod = a_ext_s * b_ext_s;
  end

  pe_pipe_reg #(.PW($bits(s1_pay_t))) u_s1 (
    .clk       (clk),
    .n_reset   (n_reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in_s),
    .out_valid (s1_valid_s),
    .out_ready (s2_ready_s),
    .out_data  (s1_q_s)
  );

  // Stage-2 arithmetic, optional clamping, then narrowing to the element width.
  always_comb begin
    c_ext_s = {{32{s1_q_s.c[31]}}, s1_q_s.c};
    case (s1_q_s.sew)
      SEW_8:   w_s = 7'd8;
      SEW_16:  w_s = 7'd16;
      default: w_s = 7'd32;
    endcase
    case (s1_q_s.op)
      PE_MUL:   wide_s = $signed(s1_q_s.prod);
      PE_MULH:  wide_s = $signed(s1_q_s.prod) >>> w_s;
      PE_MACC:  wide_s = $signed(s1_q_s.prod) + c_ext_s;
      PE_NMSAC: wide_s = c_ext_s - $signed(s1_q_s.prod);
      default:  wide_s = $signed(s1_q_s.prod);
    endcase
    s2_in_s.sat = 1'b0;
    s2_in_s.res = pe_narrow(wide_s, s1_q_s.sew);
`ifdef PE_MAC_SAT_EN
    lim_hi_s = (64'sd1 <<< (w_s - 7'd1)) - 64'sd1;
    lim_lo_s = -lim_hi_s - 64'sd1;
    if ((s1_q_s.op == PE_MACC) || (s1_q_s.op == PE_NMSAC)) begin
      if (wide_s > lim_hi_s) begin
        s2_in_s.sat = 1'b1;
        s2_in_s.res = pe_narrow(lim_hi_s, s1_q_s.sew);
      end else if (wide_s < lim_lo_s) begin
        s2_in_s.sat = 1'b1;
        s2_in_s.res = pe_narrow(lim_lo_s, s1_q_s.sew);
      end else begin
        s2_in_s.sat = 1'b0;
      end
    end else begin
      s2_in_s.sat = 1'b0;
    end
`endif
  end

  pe_pipe_reg #(.PW($bits(s2_pay_t))) u_s2 (
    .clk       (clk),
    .n_reset   (n_reset),
    .flush     (flush),
    .in_valid  (s1_valid_s),
    .in_ready  (s2_ready_s),
    .in_data   (s2_in_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_q_s)
  );

  assign result  = s2_q_s.res;
  assign out_sat = s2_q_s.sat;

`ifndef SYNTHESIS
  pe_mac_pipe_chk u_chk (
    .clk     (clk),
    .n_reset (n_reset),
    .accept  (in_valid && in_ready),
    .res_sew (res_sew)
  );
`endif

endmodule

// File: tb/tb_pe_mac_pipe.sv
// Self-checking bench for pe_mac_pipe: directed cases, backpressure, flush,
// reset and a randomized stream scored against an arithmetic reference.
module tb_pe_mac_pipe;

  logic        clk = 1'b0;
  logic        n_reset, flush, in_valid, in_ready, out_valid, out_ready, out_sat;
  logic [1:0]  op, res_sew;
  logic [31:0] op_a, op_b, op_c, result;

  int          total = 0;
  int          bad = 0;
  int          n_out = 0;
  logic [32:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [32:0] prev_val = 33'd0;

  pe_mac_pipe dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .res_sew   (res_sew),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_c      (op_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer arithmetic, optional clamp, keep W bits sign-extended.
  function automatic logic [32:0] ref_calc(input logic [1:0] o, input logic [1:0] s,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
    int     w;
    longint p, v, hi, lo;
    logic   sat;
    w   = (s == 2'd3) ? 32 : (8 << s);
    p   = longint'($signed(a)) * longint'($signed(b));
    case (o)
      2'd0:    v = p;
      2'd1:    v = p >>> w;
      2'd2:    v = p + longint'($signed(c));
      default: v = longint'($signed(c)) - p;
    endcase
    hi  = (longint'(1) << (w - 1)) - 1;
    lo  = -hi - 1;
    sat = 1'b0;
`ifdef PE_MAC_SAT_EN
    if (o >= 2'd2) begin
      if (v > hi) begin v = hi; sat = 1'b1; end
      else if (v < lo) begin v = lo; sat = 1'b1; end
    end
`endif
    if (hi < lo) sat = 1'b0;
    v = (v <<< (64 - w)) >>> (64 - w);
    return {sat, v[31:0]};
  endfunction

  // One clock: score the handshakes that will complete at the next rising edge.
  task automatic tick();
    #1;
    if (prev_stall) begin
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_data", {31'd0, out_sat, result}, {31'd0, prev_val});
    end
    if (flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) chk("spurious_out", 64'd1, 64'd0);
        else chk("result", {31'd0, out_sat, result}, {31'd0, exp_q.pop_front()});
      end
      if (in_valid && in_ready) exp_q.push_back(ref_calc(op, res_sew, op_a, op_b, op_c));
    end
    prev_stall = out_valid && !out_ready && !flush;
    prev_val   = {out_sat, result};
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] o, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    in_valid = 1'b1; op = o; res_sew = s; op_a = a; op_b = b; op_c = c;
  endtask

  // Single op with an idle pipe: exact 2-cycle latency and known result.
  task automatic run_one(input string tag, input logic [1:0] o, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] er, input logic es);
    out_ready = 1'b1;
    drive(o, s, a, b, c);
    #1 chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, {63'd0, out_valid}, 64'd0);
    tick();
    chk({tag, "_lat2"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_res"}, {32'd0, result}, {32'd0, er});
    chk({tag, "_sat"}, {63'd0, out_sat}, {63'd0, es});
    tick();
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      tick();
    end
    chk({tag, "_drained"}, {32'd0, exp_q.size()}, 64'd0);
  endtask

  initial begin
    int n0;
    logic [31:0] a, b, c;
    n_reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 2'd0; res_sew = 2'd0; op_a = 32'd0; op_b = 32'd0; op_c = 32'd0;
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", {32'd0, result}, 64'd0);
    chk("rst_out_sat", {63'd0, out_sat}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);

    run_one("mul8", 2'd0, 2'd0, 32'hFFFFFFFD, 32'd5, 32'd0, 32'hFFFFFFF1, 1'b0);
    run_one("macc16", 2'd2, 2'd1, 32'd100, 32'd200, 32'd1000, 32'h00005208, 1'b0);
    run_one("nmsac16", 2'd3, 2'd1, 32'd100, 32'd200, 32'd1000, 32'hFFFFB5C8, 1'b0);
    run_one("mulh8", 2'd1, 2'd0, 32'hFFFFFF80, 32'hFFFFFF80, 32'd0, 32'h00000040, 1'b0);
    run_one("mulh32", 2'd1, 2'd2, 32'h80000000, 32'h80000000, 32'd0, 32'h40000000, 1'b0);
`ifdef PE_MAC_SAT_EN
    run_one("macc8_ovf", 2'd2, 2'd0, 32'd100, 32'd2, 32'd100, 32'h0000007F, 1'b1);
    run_one("nmsac8_neg", 2'd3, 2'd0, 32'd100, 32'd2, 32'd0, 32'hFFFFFF80, 1'b1);
`else
    run_one("macc8_ovf", 2'd2, 2'd0, 32'd100, 32'd2, 32'd100, 32'h0000002C, 1'b0);
    run_one("nmsac8_neg", 2'd3, 2'd0, 32'd100, 32'd2, 32'd0, 32'h00000038, 1'b0);
`endif

    // Backpressure: two beats buffer, third is refused until the sink drains.
    n0 = n_out;
    out_ready = 1'b0;
    drive(2'd0, 2'd2, 32'd11, 32'd3, 32'd0);
    #1 chk("bp_rdy1", {63'd0, in_ready}, 64'd1);
    tick();
    drive(2'd0, 2'd2, 32'd12, 32'd3, 32'd0);
    #1 chk("bp_rdy2", {63'd0, in_ready}, 64'd1);
    tick();
    drive(2'd0, 2'd2, 32'd13, 32'd3, 32'd0);
    #1 chk("bp_rdy3", {63'd0, in_ready}, 64'd0);
    tick();
    tick();
    chk("bp_stall_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    #1 chk("bp_rdy_release", {63'd0, in_ready}, 64'd1);
    tick();
    drain("bp");
    chk("bp_count", n_out - n0, 64'd3);

    // Flush with two ops in flight plus one offered.
    n0 = n_out;
    out_ready = 1'b0;
    drive(2'd2, 2'd1, 32'd7, 32'd7, 32'd1);
    tick();
    drive(2'd3, 2'd1, 32'd9, 32'd9, 32'd2);
    tick();
    drive(2'd0, 2'd0, 32'd5, 32'd5, 32'd0);
    flush = 1'b1;
    #1 chk("fl_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1;
    repeat (5) tick();
    chk("fl_no_output", n_out - n0, 64'd0);

    // Same scenario, killed by an asynchronous reset pulse instead.
    out_ready = 1'b0;
    drive(2'd2, 2'd1, 32'd7, 32'd7, 32'd1);
    tick();
    drive(2'd3, 2'd1, 32'd9, 32'd9, 32'd2);
    tick();
    drive(2'd0, 2'd0, 32'd5, 32'd5, 32'd0);
    #2 n_reset = 1'b0;
    #1;
    chk("rp_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rp_result", {32'd0, result}, 64'd0);
    chk("rp_out_sat", {63'd0, out_sat}, 64'd0);
    exp_q.delete();
    prev_stall = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    n0 = n_out;
    out_ready = 1'b1;
    repeat (5) tick();
    chk("rp_no_output", n_out - n0, 64'd0);

    // Randomized stream with random source and sink pacing.
    for (int i = 0; i < 400; i++) begin
      a = $urandom; b = $urandom; c = $urandom;
      if ($urandom_range(0, 1) == 1) a = {{24{a[7]}}, a[7:0]};
      if ($urandom_range(0, 1) == 1) b = {{24{b[7]}}, b[7:0]};
      if ($urandom_range(0, 1) == 1) c = {{16{c[15]}}, c[15:0]};
      drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), a, b, c);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
